// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for a multi-cycle RV32I core.
//   Parameters: TIMEOUT - max cycles a memory request may wait for i_mem_ready (>=2)
//               CNT_W   - width of the retired-instruction counter (wraps)
//   Inputs : clk, rst_n (async, active-low), i_opcode / i_func from the IR decoder,
//            i_branch_taken (ALU compare, valid in EXEC), i_mem_ready (request done).
//   Outputs: o_mem_req / o_mem_we (unified memory handshake), o_ir_write, o_pc_write,
//            o_pc_sel (0 PC+4, 1 ALU), o_reg_write, o_wb_sel (00 ALU, 01 mem, 10 PC+4),
//            o_alu_src_a (0 rs1, 1 PC), o_alu_src_b (0 rs2, 1 imm),
//            o_alu_op (00 add, 01 branch cmp, 10 use func, 11 pass B),
//            o_trap / o_trap_cause (01 illegal opcode, 10 memory timeout), o_retired.
//   i_func is consumed by the ALU directly when o_alu_op selects it; the FSM only
//   needs the opcode.
module multicycle_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       i_opcode,
    input  logic [3:0]       i_func,
    input  logic             i_branch_taken,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_pc_sel,
    output logic             o_reg_write,
    output logic [1:0]       o_wb_sel,
    output logic             o_alu_src_a,
    output logic             o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_retired
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;
    localparam int TW = $clog2(TIMEOUT);

    logic [2:0]       r_state, w_next;
    logic [6:0]       r_op;
    logic [TW-1:0]    r_timer;
    logic [1:0]       r_cause, w_cause;
    logic [CNT_W-1:0] r_retired;
    logic w_r, w_imm, w_ld, w_st, w_br, w_jal, w_lui, w_auipc, w_legal, w_req, w_tmo;

    assign w_r     = r_op == 7'b0110011;
    assign w_imm   = r_op == 7'b0010011;
    assign w_ld    = r_op == 7'b0000011;
    assign w_st    = r_op == 7'b0100011;
    assign w_br    = r_op == 7'b1100011;
    assign w_jal   = r_op == 7'b1101111;
    assign w_lui   = r_op == 7'b0110111;
    assign w_auipc = r_op == 7'b0010111;
    assign w_legal = i_opcode inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011,
                                      7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
    assign w_req   = r_state == S_FETCH || r_state == S_MEM;
    // A ready arriving in the last allowed cycle still completes the request.
    assign w_tmo   = w_req && !i_mem_ready && r_timer == TW'(TIMEOUT - 1);
    assign o_retired = r_retired;

    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        case (r_state)
            S_FETCH: begin
                if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end else if (i_mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next  = w_legal ? S_EXEC : S_TRAP;
                w_cause = w_legal ? r_cause : 2'b01;
            end
            S_EXEC: w_next = w_br ? S_FETCH : (w_ld || w_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end else if (i_mem_ready) begin
                    w_next = w_ld ? S_WB : S_FETCH;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs are gated by rst_n so an in-flight request drops the moment reset asserts.
    always_comb begin
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_sel     = 1'b0;
        o_reg_write  = 1'b0;
        o_wb_sel     = 2'b00;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 1'b0;
        o_alu_op     = 2'b00;
        o_trap       = 1'b0;
        o_trap_cause = 2'b00;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req  = 1'b1;
                    o_ir_write = i_mem_ready;
                end
                S_EXEC: begin
                    o_alu_src_a = w_auipc | w_jal;
                    o_alu_src_b = ~(w_r | w_br);
                    o_alu_op    = w_br ? 2'b01 : w_lui ? 2'b11 : (w_r | w_imm) ? 2'b10 : 2'b00;
                    o_pc_write  = w_br;
                    o_pc_sel    = w_br & i_branch_taken;
                end
                S_MEM: begin
                    o_mem_req  = 1'b1;
                    o_mem_we   = w_st;
                    o_pc_write = w_st & i_mem_ready;
                end
                S_WB: begin
                    o_reg_write = 1'b1;
                    o_wb_sel    = w_ld ? 2'b01 : w_jal ? 2'b10 : 2'b00;
                    o_pc_write  = 1'b1;
                    o_pc_sel    = w_jal;
                end
                S_TRAP:  o_trap = 1'b1;
                default: o_trap = 1'b0;
            endcase
            o_trap_cause = r_cause;
        end
    end

    // Every instruction retires on exactly the cycle it updates the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_timer   <= '0;
            r_cause   <= 2'b00;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if (r_state == S_DECODE) r_op <= i_opcode;
            r_timer <= (w_req && !i_mem_ready && w_next == r_state) ? r_timer + 1'b1 : '0;
            if (o_pc_write) r_retired <= r_retired + 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl with a per-instruction phase model.
module tb_multicycle_ctrl;
    localparam int TMO = 8;
    localparam int CW  = 4;
    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_I = 7'b0010011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_LUI = 7'b0110111, OP_AUI = 7'b0010111, OP_BAD = 7'b1111111;
    // {mem_req, mem_we, ir_write, pc_write, pc_sel, reg_write, wb_sel[1:0], src_a, src_b, alu_op[1:0], trap}
    localparam logic [12:0] REQ = 13'h1000, WE = 13'h0800, IRW = 13'h0400, PCW = 13'h0200,
                            PCS = 13'h0100, RW = 13'h0080, WBS1 = 13'h0040, WBS0 = 13'h0020,
                            SA = 13'h0010, SB = 13'h0008, OP1 = 13'h0004, OP0 = 13'h0002,
                            TRP = 13'h0001;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] i_opcode = '0;
    logic [3:0] i_func = '0;
    logic i_branch_taken = 1'b0, i_mem_ready = 1'b0;
    logic o_mem_req, o_mem_we, o_ir_write, o_pc_write, o_pc_sel, o_reg_write;
    logic o_alu_src_a, o_alu_src_b, o_trap;
    logic [1:0] o_wb_sel, o_alu_op, o_trap_cause;
    logic [CW-1:0] o_retired;

    multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_opcode(i_opcode), .i_func(i_func),
        .i_branch_taken(i_branch_taken), .i_mem_ready(i_mem_ready),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_ir_write(o_ir_write),
        .o_pc_write(o_pc_write), .o_pc_sel(o_pc_sel), .o_reg_write(o_reg_write),
        .o_wb_sel(o_wb_sel), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_alu_op(o_alu_op), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
        .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    typedef struct { logic [6:0] op; logic rdy; logic tk; logic [12:0] exp; } cyc_t;
    typedef struct { string name; logic [6:0] op; int fw; int mw; logic tk; int lat; } tv_t;

    cyc_t q[$];
    tv_t  tbl[$];
    int errors = 0, checks = 0, model_ret = 0;

    function automatic logic [12:0] got_vec();
        return {o_mem_req, o_mem_we, o_ir_write, o_pc_write, o_pc_sel, o_reg_write, o_wb_sel,
                o_alu_src_a, o_alu_src_b, o_alu_op, o_trap};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic void add(logic [6:0] op, logic rdy, logic tk, logic [12:0] exp);
        cyc_t c;
        c.op = op; c.rdy = rdy; c.tk = tk; c.exp = exp;
        q.push_back(c);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(1));
    endfunction

    // ALU select pattern an instruction class asks for during its execute phase.
    function automatic logic [12:0] exec_bits(logic [6:0] op, logic tk);
        case (op)
            OP_R:           return OP1;
            OP_I:           return SB | OP1;
            OP_LD, OP_ST:   return SB;
            OP_LUI:         return SB | OP1 | OP0;
            OP_AUI, OP_JAL: return SA | SB;
            OP_BR:          return OP0 | PCW | (tk ? PCS : 13'h0);
            default:        return 13'h0;
        endcase
    endfunction

    // Phase sequence of one instruction: fetch waits, fetch, decode, execute, memory, writeback.
    function automatic void build(logic [6:0] op, int fw, int mw, logic tk);
        logic ld, st;
        ld = op == OP_LD;
        st = op == OP_ST;
        for (int i = 0; i < fw; i++) add(op, 1'b0, tk, REQ);
        add(op, 1'b1, tk, REQ | IRW);
        add(op, rnd(), tk, 13'h0);
        add(op, rnd(), tk, exec_bits(op, tk));
        if (op == OP_BR) return;
        if (ld || st) begin
            for (int i = 0; i < mw; i++) add(op, 1'b0, tk, REQ | (st ? WE : 13'h0));
            add(op, 1'b1, tk, st ? (REQ | WE | PCW) : REQ);
            if (st) return;
        end
        add(op, rnd(), tk, RW | PCW | (ld ? WBS0 : 13'h0) | (op == OP_JAL ? (WBS1 | PCS) : 13'h0));
    endfunction

    task automatic run_q(string name, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            i_opcode = c.op;
            i_mem_ready = c.rdy;
            i_branch_taken = c.tk;
            @(negedge clk);
            check(name, 32'(got_vec()), 32'(c.exp));
            n++;
            if (o_pc_write && lat < 0) lat = n;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(string name, logic [6:0] op, int fw, int mw, logic tk, int exp_lat);
        int lat;
        build(op, fw, mw, tk);
        run_q(name, lat);
        model_ret++;
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_retired"}, 32'(o_retired), model_ret % (1 << CW));
    endtask

    task automatic do_reset(string name);
        rst_n = 1'b0;
        #1;
        check({name, "_rst_outs"}, 32'(got_vec()), 0);
        check({name, "_rst_cause"}, 32'(o_trap_cause), 0);
        check({name, "_rst_retired"}, 32'(o_retired), 0);
        model_ret = 0;
        i_mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        logic [6:0] ops [8];
        ops = '{OP_R, OP_LD, OP_I, OP_ST, OP_BR, OP_JAL, OP_LUI, OP_AUI};
        tbl.push_back('{"add",      OP_R,   0, 0, 1'b0, 4});
        tbl.push_back('{"lw_wait3", OP_LD,  0, 3, 1'b0, 8});
        tbl.push_back('{"beq_t",    OP_BR,  0, 0, 1'b1, 3});
        tbl.push_back('{"beq_nt",   OP_BR,  0, 0, 1'b0, 3});
        tbl.push_back('{"sw",       OP_ST,  0, 0, 1'b0, 4});
        tbl.push_back('{"addi",     OP_I,   0, 0, 1'b0, 4});
        tbl.push_back('{"lui",      OP_LUI, 0, 0, 1'b0, 4});
        tbl.push_back('{"auipc",    OP_AUI, 0, 0, 1'b0, 4});
        tbl.push_back('{"jal",      OP_JAL, 0, 0, 1'b1, 4});
        tbl.push_back('{"lw_f2",    OP_LD,  2, 0, 1'b0, 7});
        tbl.push_back('{"sw_f1m2",  OP_ST,  1, 2, 1'b0, 7});
        tbl.push_back('{"add_f7",   OP_R,   7, 0, 1'b0, 11});

        #12;
        check("reset_outs", 32'(got_vec()), 0);
        check("reset_retired", 32'(o_retired), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) instr(tbl[i].name, tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].tk, tbl[i].lat);

        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            int fw, mw, el;
            logic tk;
            op = ops[$urandom_range(7)];
            fw = $urandom_range(TMO - 1);
            mw = $urandom_range(TMO - 1);
            tk = rnd();
            el = op == OP_BR ? 3 + fw : op == OP_LD ? 5 + fw + mw : op == OP_ST ? 4 + fw + mw : 4 + fw;
            instr("rand", op, fw, (op == OP_LD || op == OP_ST) ? mw : 0, tk, el);
        end

        add(OP_BAD, 1'b1, 1'b0, REQ | IRW);
        add(OP_BAD, 1'b0, 1'b0, 13'h0);
        for (int i = 0; i < 100; i++) add(OP_BAD, rnd(), 1'b0, TRP);
        run_q("illegal", lat);
        check("illegal_cause", 32'(o_trap_cause), 1);
        check("illegal_retired", 32'(o_retired), model_ret % (1 << CW));
        do_reset("illegal");
        #3;
        check("after_reset_trap", 32'(o_trap), 0);
        check("after_reset_req", 32'(o_mem_req), 1);

        for (int i = 0; i < TMO; i++) add(OP_R, 1'b0, 1'b0, REQ);
        for (int i = 0; i < 5; i++) add(OP_R, rnd(), 1'b0, TRP);
        run_q("fetch_tmo", lat);
        check("fetch_tmo_cause", 32'(o_trap_cause), 2);
        do_reset("fetch_tmo");
        instr("fetch_ready_last", OP_R, TMO - 1, 0, 1'b0, TMO + 3);

        add(OP_LD, 1'b1, 1'b0, REQ | IRW);
        add(OP_LD, 1'b0, 1'b0, 13'h0);
        add(OP_LD, 1'b0, 1'b0, SB);
        for (int i = 0; i < TMO; i++) add(OP_LD, 1'b0, 1'b0, REQ);
        for (int i = 0; i < 3; i++) add(OP_LD, rnd(), 1'b0, TRP);
        run_q("mem_tmo", lat);
        check("mem_tmo_cause", 32'(o_trap_cause), 2);
        do_reset("mem_tmo");

        for (int i = 0; i < 17; i++) instr("wrap_sw", OP_ST, 0, 0, 1'b0, 4);
        check("wrap_final", 32'(o_retired), 1);

        add(OP_ST, 1'b1, 1'b0, REQ | IRW);
        add(OP_ST, 1'b0, 1'b0, 13'h0);
        add(OP_ST, 1'b0, 1'b0, SB);
        run_q("rst_mid", lat);
        i_mem_ready = 1'b0;
        #1;
        check("rst_mid_pre", 32'(got_vec()), 32'(REQ | WE));
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'({o_mem_req, o_mem_we}), 0);
        check("rst_mid_outs", 32'(got_vec()), 0);
        check("rst_mid_retired", 32'(o_retired), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ret = 0;
        instr("post_rst_add", OP_R, 0, 0, 1'b0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
